mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB register; produces the MEM_load_data value that MEM/WB captures.
- Drives a valid/ready data-memory request channel with a separate response channel. Aligns store data and byte strobes, and aligns and extends load data.
- Stalls the pipeline until the access completes. Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ plus RESP before the access is aborted with mem_bus_err.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- EX_alu_result  in  32  effective byte address
- EX_rs2_data  in  32  store source data
- EX_funct3  in  3  access size/sign (RV32 load/store encoding)
- EX_MemRead  in  1  load present
- EX_MemWrite  in  1  store present
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = write
- dmem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_wstrb  out  4  byte enables
- dmem_rsp_valid  in  1  read data valid
- dmem_rsp_rdata  in  32  read word
- MEM_load_data  out  32  aligned, extended load result (registered)
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_misalign  out  1  misaligned or illegal access (combinational)
- mem_bus_err  out  1  one-cycle timeout pulse (registered)

Behaviour:
- Reset (synchronous): state=IDLE, counter=0.
  - dmem_req_valid, dmem_req_we, dmem_req_wstrb, dmem_req_addr, dmem_req_wdata, MEM_load_data and mem_bus_err all reset to 0.
  - mem_stall and mem_misalign are forced to 0 while rst=1.
- access = EX_MemRead | EX_MemWrite.
- illegal (reported on mem_misalign) when any of:
  - MemRead and MemWrite both asserted;
  - funct3 is not a legal encoding (load: 000/001/010/100/101; store: 000/001/010);
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00.
- On illegal: no request issued, mem_stall=0, MEM_load_data unchanged.
- FSM:
  - IDLE:
    - access & !illegal: latch we/addr/wdata/wstrb/funct3/addr[1:0], mem_stall=1, go to REQ.
    - Otherwise stay in IDLE, mem_stall=0.
  - REQ:
    - dmem_req_valid=1; all request fields held stable until ready; mem_stall=1.
    - On dmem_req_ready: store → DONE; load → RESP.
  - RESP:
    - mem_stall=1.
    - dmem_rsp_valid is honoured only in this state; the earliest response is the cycle after acceptance.
    - On dmem_rsp_valid: MEM_load_data <= formatted rdata; go to DONE.
  - DONE:
    - mem_stall=0 for exactly one cycle, so EX/MEM advances; always → IDLE.
    - No request is launched in DONE, even though the EX inputs still show the completed instruction.
  - Timeout:
    - Counter clears on entry to REQ and increments each cycle in REQ or RESP.
    - When it reaches TIMEOUT: mem_bus_err=1 for one cycle, MEM_load_data <= 0 for loads, go to DONE, dmem_req_valid drops.
- Minimum stall with ready asserted in the first REQ cycle: store 2 cycles, load 3 cycles.
- Store alignment:
  - SB (000): wdata = byte replicated to all 4 lanes; wstrb = 0001 << addr[1:0].
  - SH (001): wdata = {h,h}; wstrb = 0011 when addr[1]=0, 1100 when addr[1]=1.
  - SW (010): wdata = rs2; wstrb = 1111.
- Load formatting: select byte addr[1:0] or half addr[1]:
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half.
  - LW (010): whole word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
- MEM_load_data holds its value when no load completes.
- A mid-operation reset abandons the access. A stale rsp_valid arriving after reset is ignored, because the FSM is no longer in RESP.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum: IDLE, REQ, RESP, DONE;
  - strobe width.
- One combinational sub-module, load_align, maps (rdata, offset, funct3) to a 32-bit result.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, ready in the first REQ cycle → req addr 0x100, wstrb 1111, wdata 0xDEADBEEF, mem_stall high for exactly 2 cycles.
- LB, addr 0x203, rdata 0x80FF1234 one cycle after accept → MEM_load_data 0x0000FF80? No: byte 3 = 0x80, so MEM_load_data 0xFFFFFF80. Repeat as LBU → 0x00000080. Stall 3 cycles.
- SH, addr 0x102, rs2 0x0000ABCD → wdata 0xABCDABCD, wstrb 1100. SB, addr 0x101, rs2 0x55 → wdata 0x55555555, wstrb 0010.
- LW, addr 0x101 → no dmem_req_valid, mem_misalign=1, mem_stall=0, MEM_load_data unchanged. MemRead and MemWrite both asserted → same response.
- LW with ready held low → mem_bus_err pulse in the cycle after TIMEOUT, MEM_load_data=0, valid dropped, DONE, stall released.
- rst asserted for one cycle while in RESP, then rsp_valid=1 with 0x12345678 → state IDLE, all outputs 0, MEM_load_data stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32 size encodings,
// FSM states and the store lane-alignment helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  // Narrow stores replicate their data so memory can pick any lane via wstrb.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_B:    return {4{data[7:0]}};
      F3_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] store_wstrb(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B:    return STRB_W'(1) << offset;
      F3_H:    return offset[1] ? 4'b1100 : 4'b0011;
      default: return {STRB_W{1'b1}};
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(rdata >> {offset, 3'b000});
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues one valid/ready data-memory request per
// legal access, stalls the pipeline until it completes, and aborts on timeout.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       EX_alu_result,
  input  logic [31:0]       EX_rs2_data,
  input  logic [2:0]        EX_funct3,
  input  logic              EX_MemRead,
  input  logic              EX_MemWrite,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [31:0]       dmem_req_addr,
  output logic [31:0]       dmem_req_wdata,
  output logic [STRB_W-1:0] dmem_req_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rsp_rdata,
  output logic [31:0]       MEM_load_data,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              mem_bus_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [31:0]        addr_q, wdata_q, load_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic               bus_err_q;
  logic               access, illegal, f3_ok, start, timeout_hit, abort;
  logic [31:0]        aligned;

  // Legality check on the EX/MEM contents.
  assign access = EX_MemRead | EX_MemWrite;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    f3_ok = 1'b0;
    if (EX_MemWrite) f3_ok = EX_funct3 inside {F3_B, F3_H, F3_W};
    else             f3_ok = EX_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  end

  assign illegal = (EX_MemRead & EX_MemWrite) | ~f3_ok
                 | ((EX_funct3[1:0] == 2'b01) & EX_alu_result[0])
                 | ((EX_funct3 == F3_W) & (EX_alu_result[1:0] != 2'b00));

  assign start       = (state_q == IDLE) & access & ~illegal;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; a completion in the last allowed cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = REQ;
      REQ: begin
        if (dmem_req_ready && we_q) state_d = DONE;
        else if (timeout_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end else if (dmem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (dmem_rsp_valid) state_d = DONE;
        else if (timeout_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; all handshake outputs are forced low in reset.
  always_comb begin
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    mem_stall = start;
        REQ: begin
          dmem_req_valid = 1'b1;
          mem_stall      = 1'b1;
        end
        RESP:    mem_stall = 1'b1;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  assign mem_misalign = ~rst & access & illegal;

  load_align u_load_align (
    .rdata  (dmem_rsp_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (aligned)
  );

  // Request fields are latched on launch so they stay stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control and output registers need reset; there is no storage array here.
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      load_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= abort;
      if (start) begin
        cnt_q   <= '0;
        we_q    <= EX_MemWrite;
        addr_q  <= {EX_alu_result[31:2], 2'b00};
        wdata_q <= EX_MemWrite ? store_wdata(EX_funct3, EX_rs2_data) : 32'h0;
        wstrb_q <= EX_MemWrite ? store_wstrb(EX_funct3, EX_alu_result[1:0]) : '0;
        f3_q    <= EX_funct3;
        off_q   <= EX_alu_result[1:0];
      end else if (state_q == REQ || state_q == RESP) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == RESP && dmem_rsp_valid) load_q <= aligned;
      else if (abort && !we_q)               load_q <= '0;
    end
  end

  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_wstrb = wstrb_q;
  assign MEM_load_data  = load_q;
  assign mem_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, loads, illegal accesses,
// bus timeout and mid-access reset, each checked against hand-computed values.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EX_alu_result, EX_rs2_data;
  logic [2:0]  EX_funct3;
  logic        EX_MemRead, EX_MemWrite;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata, MEM_load_data;
  logic        mem_stall, mem_misalign, mem_bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .EX_alu_result(EX_alu_result), .EX_rs2_data(EX_rs2_data), .EX_funct3(EX_funct3),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .MEM_load_data(MEM_load_data), .mem_stall(mem_stall),
    .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    EX_MemRead    = 1'b0;
    EX_MemWrite   = 1'b0;
    EX_alu_result = 32'h0;
    EX_rs2_data   = 32'h0;
    EX_funct3     = 3'b000;
  endtask

  // Drives one access and plays the memory: ready held at rdy, response one
  // cycle after a load is accepted. Stops at the first unstalled cycle (DONE).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic rdy, input int bound,
                            output int stall_cycles, output int valid_cycles,
                            output logic [31:0] cap_addr, output logic [31:0] cap_wdata,
                            output logic [3:0] cap_wstrb, output logic cap_we,
                            output logic done_seen, output logic err_at_done,
                            output logic valid_at_done);
    logic pend;
    stall_cycles = 0; valid_cycles = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0; cap_we = 1'b0;
    done_seen = 1'b0; err_at_done = 1'b0; valid_at_done = 1'b0;
    pend = 1'b0;
    EX_MemRead = rd; EX_MemWrite = wr; EX_alu_result = addr; EX_rs2_data = data; EX_funct3 = f3;
    dmem_req_ready = rdy;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (c > 0 && !mem_stall) begin
        done_seen     = 1'b1;
        err_at_done   = mem_bus_err;
        valid_at_done = dmem_req_valid;
        break;
      end
      if (mem_stall) stall_cycles++;
      if (dmem_req_valid) begin
        valid_cycles++;
        cap_addr = dmem_req_addr; cap_wdata = dmem_req_wdata;
        cap_wstrb = dmem_req_wstrb; cap_we = dmem_req_we;
        pend = rdy && !wr;
      end
      @(posedge clk);
      #1;
      dmem_rsp_valid = pend;
      dmem_rsp_rdata = pend ? rdata : 32'h0;
      pend = 1'b0;
    end
    idle_inputs();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    EX_MemRead = 1'b1; EX_alu_result = 32'h101; EX_funct3 = F3_W;
    step(); step();
    @(negedge clk);
    checks++; if (mem_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", mem_misalign); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", mem_stall); end
    checks++; if ({dmem_req_valid, dmem_req_we, dmem_req_wstrb, mem_bus_err} !== 7'h0) begin
      errors++; $display("FAIL rst_ctrl got=%b exp=0", {dmem_req_valid, dmem_req_we, dmem_req_wstrb, mem_bus_err}); end
    checks++; if ({dmem_req_addr, dmem_req_wdata, MEM_load_data} !== 96'h0) begin
      errors++; $display("FAIL rst_data got=%h exp=0", {dmem_req_addr, dmem_req_wdata, MEM_load_data}); end
    idle_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_word;
    int sc, vc; logic [31:0] a, w; logic [3:0] s; logic we, dn, er, vd;
    run_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, F3_W, 32'h0, 1'b1, 20, sc, vc, a, w, s, we, dn, er, vd);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL sw_done got=%b exp=1", dn); end
    checks++; if (sc !== 2) begin errors++; $display("FAIL sw_stall got=%0d exp=2", sc); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL sw_valid_cycles got=%0d exp=1", vc); end
    checks++; if (a !== 32'h100) begin errors++; $display("FAIL sw_addr got=%h exp=00000100", a); end
    checks++; if (w !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", w); end
    checks++; if (s !== 4'b1111) begin errors++; $display("FAIL sw_wstrb got=%b exp=1111", s); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_we got=%b exp=1", we); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_bus_err got=%b exp=0", er); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [3]  = '{F3_B, F3_H, F3_BU};
    logic [31:0] ads [3]  = '{32'h203, 32'h202, 32'h203};
    logic [31:0] exps [3] = '{32'hFFFFFF80, 32'hFFFF80FF, 32'h00000080};
    int sc, vc; logic [31:0] a, w; logic [3:0] s; logic we, dn, er, vd;
    for (int i = 0; i < 3; i++) begin
      run_access(1'b1, 1'b0, ads[i], 32'h0, f3s[i], 32'h80FF1234, 1'b1, 20, sc, vc, a, w, s, we, dn, er, vd);
      checks++; if (sc !== 3) begin errors++; $display("FAIL ld%0d_stall got=%0d exp=3", i, sc); end
      checks++; if (a !== 32'h200 || we !== 1'b0) begin errors++; $display("FAIL ld%0d_req got=%h/%b exp=00000200/0", i, a, we); end
      checks++; if (MEM_load_data !== exps[i]) begin errors++; $display("FAIL ld%0d_data got=%h exp=%h", i, MEM_load_data, exps[i]); end
    end
  endtask

  task automatic test_store_narrow;
    logic [2:0]  f3s [2]  = '{F3_H, F3_B};
    logic [31:0] ads [2]  = '{32'h102, 32'h101};
    logic [31:0] dat [2]  = '{32'h0000ABCD, 32'h00000055};
    logic [31:0] expw [2] = '{32'hABCDABCD, 32'h55555555};
    logic [3:0]  exps [2] = '{4'b1100, 4'b0010};
    int sc, vc; logic [31:0] a, w; logic [3:0] s; logic we, dn, er, vd;
    for (int i = 0; i < 2; i++) begin
      run_access(1'b0, 1'b1, ads[i], dat[i], f3s[i], 32'h0, 1'b1, 20, sc, vc, a, w, s, we, dn, er, vd);
      checks++; if (w !== expw[i]) begin errors++; $display("FAIL st%0d_wdata got=%h exp=%h", i, w, expw[i]); end
      checks++; if (s !== exps[i]) begin errors++; $display("FAIL st%0d_wstrb got=%b exp=%b", i, s, exps[i]); end
      checks++; if (a !== 32'h100 || sc !== 2) begin errors++; $display("FAIL st%0d_addr_stall got=%h/%0d exp=00000100/2", i, a, sc); end
    end
    checks++; if (MEM_load_data !== 32'h00000080) begin errors++; $display("FAIL st_load_hold got=%h exp=00000080", MEM_load_data); end
  endtask

  task automatic test_misalign;
    logic        rds [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{F3_W, F3_W, 3'b011, 3'b100};
    logic [31:0] ads [4] = '{32'h101, 32'h100, 32'h100, 32'h100};
    int bad;
    for (int i = 0; i < 4; i++) begin
      bad = 0;
      EX_MemRead = rds[i]; EX_MemWrite = wrs[i]; EX_funct3 = f3s[i];
      EX_alu_result = ads[i]; EX_rs2_data = 32'h12345678;
      dmem_req_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (mem_misalign !== 1'b1 || mem_stall !== 1'b0 || dmem_req_valid !== 1'b0) bad++;
        step();
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL illegal%0d bad_cycles got=%0d exp=0", i, bad); end
      checks++; if (MEM_load_data !== 32'h00000080) begin errors++; $display("FAIL illegal%0d_load got=%h exp=00000080", i, MEM_load_data); end
    end
    idle_inputs();
    dmem_req_ready = 1'b0;
    step();
  endtask

  task automatic test_timeout;
    int sc, vc; logic [31:0] a, w; logic [3:0] s; logic we, dn, er, vd;
    run_access(1'b1, 1'b0, 32'h300, 32'h0, F3_W, 32'h0, 1'b0, 400, sc, vc, a, w, s, we, dn, er, vd);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL to_done got=%b exp=1", dn); end
    checks++; if (vc !== 255) begin errors++; $display("FAIL to_valid_cycles got=%0d exp=255", vc); end
    checks++; if (sc !== 256) begin errors++; $display("FAIL to_stall got=%0d exp=256", sc); end
    checks++; if (er !== 1'b1 || vd !== 1'b0) begin errors++; $display("FAIL to_err_valid got=%b/%b exp=1/0", er, vd); end
    checks++; if (MEM_load_data !== 32'h0) begin errors++; $display("FAIL to_load got=%h exp=00000000", MEM_load_data); end
    checks++; if (mem_bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse got=%b exp=0", mem_bus_err); end
  endtask

  task automatic test_reset_mid;
    EX_MemRead = 1'b1; EX_funct3 = F3_W; EX_alu_result = 32'h400;
    dmem_req_ready = 1'b1;
    step(); step();
    dmem_req_ready = 1'b0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b1 || dmem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_resp got=%b/%b exp=1/0", mem_stall, dmem_req_valid); end
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h12345678;
    @(negedge clk);
    checks++; if ({mem_stall, dmem_req_valid, dmem_req_we, dmem_req_wstrb, mem_bus_err} !== 8'h0) begin
      errors++; $display("FAIL mid_ctrl got=%b exp=0", {mem_stall, dmem_req_valid, dmem_req_we, dmem_req_wstrb, mem_bus_err}); end
    checks++; if ({dmem_req_addr, dmem_req_wdata} !== 64'h0) begin
      errors++; $display("FAIL mid_req got=%h exp=0", {dmem_req_addr, dmem_req_wdata}); end
    step();
    dmem_rsp_valid = 1'b0;
    checks++; if (MEM_load_data !== 32'h0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL mid_stale got=%h/%b exp=00000000/0", MEM_load_data, mem_stall); end
  endtask

  initial begin
    idle_inputs();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'h0;
    test_reset();
    test_store_word();
    test_loads();
    test_store_narrow();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
